enc_m_n_seq: RTL and testbench

ENC_M_N_SEQ -- requirements
Module: enc_m_n_seq

---
 rtl/enc_pkg.sv | 23 ++
 rtl/prio_enc_m_n.sv | 22 ++
 rtl/enc_m_n_seq.sv | 120 ++++++++++++
 tb/tb_enc_m_n_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the sequential M-to-N bit-vector encoder.
package enc_pkg;

    // Controller states: waiting for a vector, or streaming its set-bit indices.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    // Ceiling log2, usable in constant expressions (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_enc_m_n.sv
// Combinational LSB-priority encoder: index of the lowest set bit plus an any-set flag.
module prio_enc_m_n #(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic [M-1:0] vec,
    output logic [N-1:0] idx,
    output logic         any_set
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx     = '0;
        any_set = |vec;
        for (int i = M - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = N'(i);
            end
        end
    end

endmodule

// File: rtl/enc_m_n_seq.sv
// Sequential encoder: captures a bit vector and emits one beat per set bit,
// lowest index first, with a single beat for an all-zero vector.
module enc_m_n_seq
    import enc_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_zero,
    output logic         out_onehot
);

    generate
        if (M < 2 || N < clog2(M)) begin : g_bad_params
            $error("enc_m_n_seq: M must be >= 2 and N >= clog2(M)");
        end
    endgenerate

    enc_state_t   state;
    enc_state_t   state_next;
    logic [M-1:0] pending;
    logic [M-1:0] pending_next;
    logic         zero_flag;
    logic         zero_next;
    logic         onehot_flag;
    logic         onehot_next;

    logic [N-1:0] enc_idx;
    logic         enc_any;
    logic [M-1:0] pending_low_cleared;
    logic         pending_last;
    logic         in_single;
    logic         is_emit;

    prio_enc_m_n #(
        .M(M),
        .N(N)
    ) u_prio (
        .vec    (pending),
        .idx    (enc_idx),
        .any_set(enc_any)
    );

    // Bit tricks on the pending vector: drop its lowest set bit, and detect
    // whether at most one bit remains (empty or exactly one set).
    always_comb begin
        pending_low_cleared = pending & (pending - M'(1));
        pending_last        = ~enc_any | ~(|pending_low_cleared);
        in_single           = (|in_vec) & ~(|(in_vec & (in_vec - M'(1))));
        is_emit             = (state == EMIT);
    end

    // Handshake outputs depend only on registered state, never on out_ready.
    always_comb begin
        in_ready   = ~is_emit;
        out_valid  = is_emit;
        out_idx    = is_emit ? enc_idx : '0;
        out_last   = is_emit & pending_last;
        out_zero   = is_emit & zero_flag;
        out_onehot = is_emit & onehot_flag;
    end

    // Next-state logic: capture in IDLE, peel off one bit per accepted beat in EMIT.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        zero_next    = zero_flag;
        onehot_next  = onehot_flag;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_vec;
                    zero_next    = ~(|in_vec);
                    onehot_next  = in_single;
                    state_next   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (pending_last) begin
                        pending_next = '0;
                        zero_next    = 1'b0;
                        onehot_next  = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        pending_next = pending_low_cleared;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset wins over any handshake and drops a partial vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            zero_flag   <= 1'b0;
            onehot_flag <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            zero_flag   <= zero_next;
            onehot_flag <= onehot_next;
        end
    end

endmodule

// File: tb/tb_enc_m_n_seq.sv
// Directed bench for enc_m_n_seq: table of vectors for M=4 plus hand-written
// stall, reset and M=8 sequences.
module tb_enc_m_n_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_zero;
    logic       out_onehot;

    logic [7:0] in_vec8;
    logic       in_valid8;
    logic       in_ready8;
    logic [3:0] out_idx8;
    logic       out_valid8;
    logic       out_ready8;
    logic       out_last8;
    logic       out_zero8;
    logic       out_onehot8;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic [3:0] vec;
        int         beats;
        logic [7:0] idxs;
        logic       zero;
        logic       onehot;
    } vec_rec_t;

    vec_rec_t tbl[7];

    // Free-running clock; stimulus and sampling happen on the falling edge.
    always #5 clk = ~clk;

    enc_m_n_seq #(.M(4), .N(2)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_onehot(out_onehot)
    );

    enc_m_n_seq #(.M(8), .N(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_idx   (out_idx8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_last  (out_last8),
        .out_zero  (out_zero8),
        .out_onehot(out_onehot8)
    );

    task automatic applyStimulus(input logic [3:0] vec, input logic valid, input logic ready);
        in_vec    = vec;
        in_valid  = valid;
        out_ready = ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBeat(input string name, input logic [1:0] idx, input logic last,
                             input logic zero, input logic onehot);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({name, " out_idx"}, 32'(out_idx), 32'(idx));
        checkOutput({name, " out_last"}, 32'(out_last), 32'(last));
        checkOutput({name, " out_zero"}, 32'(out_zero), 32'(zero));
        checkOutput({name, " out_onehot"}, 32'(out_onehot), 32'(onehot));
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, " out_idx"}, 32'(out_idx), 32'd0);
        checkOutput({name, " out_last"}, 32'(out_last), 32'd0);
        checkOutput({name, " out_zero"}, 32'(out_zero), 32'd0);
        checkOutput({name, " out_onehot"}, 32'(out_onehot), 32'd0);
    endtask

    // Main sequence: reset, table sweep, then the multi-cycle corner cases.
    initial begin
        // Index lists are packed two bits per beat, first beat in the low bits.
        tbl[0] = '{4'b0100, 1, 8'h02, 1'b0, 1'b1};
        tbl[1] = '{4'b1011, 3, 8'h34, 1'b0, 1'b0};
        tbl[2] = '{4'b0000, 1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 1, 8'h03, 1'b0, 1'b1};
        tbl[4] = '{4'b1111, 4, 8'hE4, 1'b0, 1'b0};
        tbl[5] = '{4'b0110, 2, 8'h09, 1'b0, 1'b0};
        tbl[6] = '{4'b1010, 2, 8'h0D, 1'b0, 1'b0};

        rst        = 1'b1;
        in_vec8    = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        checkOutput("reset dut8 in_ready", 32'(in_ready8), 32'd1);
        checkOutput("reset dut8 out_valid", 32'(out_valid8), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        for (int v = 0; v < 7; v++) begin
            checkOutput($sformatf("vec%0d in_ready before", v), 32'(in_ready), 32'd1);
            applyStimulus(tbl[v].vec, 1'b1, 1'b1);
            @(negedge clk);
            applyStimulus(4'b0000, 1'b0, 1'b1);
            for (int b = 0; b < tbl[v].beats; b++) begin
                checkBeat($sformatf("vec%0d beat%0d", v, b), tbl[v].idxs[b*2 +: 2],
                          (b == tbl[v].beats - 1), tbl[v].zero, tbl[v].onehot);
                @(negedge clk);
            end
            checkIdle($sformatf("vec%0d done", v));
        end

        // Stall on 0110 with a competing in_valid that must be ignored.
        applyStimulus(4'b0110, 1'b1, 1'b0);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(4'b1000, 1'b1, 1'b0);
            checkBeat($sformatf("stall%0d", s), 2'd1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end
        checkBeat("stall release", 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        checkBeat("stall second", 2'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkIdle("stall done");
        @(negedge clk);
        checkIdle("stall no ghost");

        // Reset in the middle of 1111 after the second beat.
        applyStimulus(4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkBeat("midrst beat0", 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkBeat("midrst beat1", 2'd1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdle("midrst after");
        @(negedge clk);
        checkIdle("midrst still idle");

        // Reset wins over a simultaneous acceptance.
        applyStimulus(4'b0100, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkIdle("rst vs accept");

        // Wider instance: 8'h81 gives index 0 then 7, zero-extended to 4 bits.
        in_vec8    = 8'h81;
        in_valid8  = 1'b1;
        out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        checkOutput("m8 beat0 out_valid", 32'(out_valid8), 32'd1);
        checkOutput("m8 beat0 out_idx", 32'(out_idx8), 32'd0);
        checkOutput("m8 beat0 out_last", 32'(out_last8), 32'd0);
        checkOutput("m8 beat0 out_onehot", 32'(out_onehot8), 32'd0);
        @(negedge clk);
        checkOutput("m8 beat1 out_valid", 32'(out_valid8), 32'd1);
        checkOutput("m8 beat1 out_idx", 32'(out_idx8), 32'd7);
        checkOutput("m8 beat1 idx msb", 32'(out_idx8[3]), 32'd0);
        checkOutput("m8 beat1 out_last", 32'(out_last8), 32'd1);
        checkOutput("m8 beat1 out_zero", 32'(out_zero8), 32'd0);
        @(negedge clk);
        checkOutput("m8 done out_valid", 32'(out_valid8), 32'd0);
        checkOutput("m8 done in_ready", 32'(in_ready8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
